// File: rtl/bist_pkg.sv
// ----------------------------------------------------------------------------
// bist_pkg : shared state encoding, default polynomials and run-length helper.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_INIT    = 3'd1,
      ST_SHIFT   = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_UNLOAD  = 3'd4,
      ST_COMPARE = 3'd5,
      ST_DONE    = 3'd6
   } bist_state_e;

   localparam logic [7:0]  C_DEF_LFSR_POLY = 8'hB8;
   localparam logic [15:0] C_DEF_MISR_POLY = 16'hB400;

   // Cycles from the start-sampling edge until bist_end is high.
   function automatic int bist_run_cycles(input int scan_len, input int n_patterns);
      return 1 + n_patterns * (scan_len + 1) + scan_len + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bist_misr_p.sv
// ----------------------------------------------------------------------------
// bist_misr_p : parametrised MISR with step enable and synchronous clear.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bist_misr_p
   import bist_pkg::*;
#(
   parameter int           W    = 16,
   parameter logic [W-1:0] POLY = W'(C_DEF_MISR_POLY)
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] sig
);

   logic [W-1:0] sig_q;
   logic [W-1:0] sig_d;

   always_comb begin
      sig_d = sig_q;
      if (clr) begin
         sig_d = '0;
      end else if (en) begin
         sig_d = {sig_q[W-2:0], ^(sig_q & POLY)} ^ d;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

`default_nettype wire

// File: rtl/bist_engine.sv
// ----------------------------------------------------------------------------
// bist_engine : LFSR pattern source, scan shift/capture sequencer, MISR check.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bist_engine
   import bist_pkg::*;
#(
   parameter int                N_IN       = 4,
   parameter int                N_OUT      = 4,
   parameter int                LFSR_W     = 8,
   parameter logic [LFSR_W-1:0] LFSR_POLY  = LFSR_W'(C_DEF_LFSR_POLY),
   parameter logic [LFSR_W-1:0] LFSR_SEED  = LFSR_W'(8'hFF),
   parameter int                MISR_W     = 16,
   parameter logic [MISR_W-1:0] MISR_POLY  = MISR_W'(C_DEF_MISR_POLY),
   parameter int                SCAN_LEN   = 8,
   parameter int                N_PATTERNS = 16,
   parameter logic [MISR_W-1:0] GOLDEN_SIG = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              bist_start,
   input  logic              bist_abort,
   input  logic [N_IN-1:0]   func_in,
   output logic [N_IN-1:0]   cut_in,
   input  logic [N_OUT-1:0]  cut_out,
   output logic              scan_en,
   output logic              scan_in,
   input  logic              cut_scan_out,
   output logic              bist_running,
   output logic              bist_end,
   output logic              pass_fail,
   output logic [MISR_W-1:0] signature
);

   if (N_IN > LFSR_W) begin : g_chk_n_in
      $error("bist_engine: N_IN must not exceed LFSR_W");
   end
   if (N_OUT + 1 > MISR_W) begin : g_chk_n_out
      $error("bist_engine: N_OUT+1 must not exceed MISR_W");
   end
   if (SCAN_LEN < 1) begin : g_chk_scan_len
      $error("bist_engine: SCAN_LEN must be at least 1");
   end
   if (N_PATTERNS < 1) begin : g_chk_n_patterns
      $error("bist_engine: N_PATTERNS must be at least 1");
   end

   localparam int SC_W = $clog2(SCAN_LEN + 1);
   localparam int PC_W = $clog2(N_PATTERNS + 1);
   localparam logic [SC_W-1:0] C_SHIFT_LAST = SC_W'(SCAN_LEN - 1);
   localparam logic [PC_W-1:0] C_PAT_LAST   = PC_W'(N_PATTERNS - 1);

   bist_state_e       state_q, state_d;
   logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_step;
   logic [SC_W-1:0]   shift_cnt_q, shift_cnt_d;
   logic [PC_W-1:0]   pat_cnt_q, pat_cnt_d;
   logic              pass_fail_q, pass_fail_d;
   logic              misr_en, misr_clr;
   logic [MISR_W-1:0] misr_din, misr_sig;

   assign lfsr_step = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_POLY)};
   assign misr_din  = MISR_W'({cut_out, cut_scan_out});

   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      shift_cnt_d = shift_cnt_q;
      pat_cnt_d   = pat_cnt_q;
      pass_fail_d = pass_fail_q;
      scan_en     = 1'b0;
      scan_in     = 1'b0;
      misr_en     = 1'b0;
      misr_clr    = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bist_start) begin
               state_d     = ST_INIT;
               pass_fail_d = 1'b0;
            end
         end
         ST_INIT: begin
            lfsr_d      = LFSR_SEED;
            misr_clr    = 1'b1;
            shift_cnt_d = '0;
            pat_cnt_d   = '0;
            state_d     = ST_SHIFT;
         end
         ST_SHIFT: begin
            scan_en = 1'b1;
            scan_in = lfsr_q[LFSR_W-1];
            lfsr_d  = lfsr_step;
            misr_en = 1'b1;
            if (shift_cnt_q == C_SHIFT_LAST) begin
               shift_cnt_d = '0;
               state_d     = ST_CAPTURE;
            end else begin
               shift_cnt_d = shift_cnt_q + SC_W'(1);
            end
         end
         ST_CAPTURE: begin
            lfsr_d  = lfsr_step;
            misr_en = 1'b1;
            if (pat_cnt_q == C_PAT_LAST) begin
               state_d = ST_UNLOAD;
            end else begin
               pat_cnt_d = pat_cnt_q + PC_W'(1);
               state_d   = ST_SHIFT;
            end
         end
         ST_UNLOAD: begin
            // Flush the last captured response; the LFSR stays frozen here.
            scan_en = 1'b1;
            misr_en = 1'b1;
            if (shift_cnt_q == C_SHIFT_LAST) begin
               shift_cnt_d = '0;
               state_d     = ST_COMPARE;
            end else begin
               shift_cnt_d = shift_cnt_q + SC_W'(1);
            end
         end
         ST_COMPARE: begin
            pass_fail_d = (misr_sig == GOLDEN_SIG);
            state_d     = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort wins over everything, including a same-cycle start.
      if (bist_abort) begin
         state_d     = ST_IDLE;
         pass_fail_d = 1'b0;
         shift_cnt_d = '0;
         pat_cnt_d   = '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         lfsr_q      <= LFSR_SEED;
         shift_cnt_q <= '0;
         pat_cnt_q   <= '0;
         pass_fail_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         shift_cnt_q <= shift_cnt_d;
         pat_cnt_q   <= pat_cnt_d;
         pass_fail_q <= pass_fail_d;
      end
   end

   bist_misr_p #(
      .W    (MISR_W),
      .POLY (MISR_POLY)
   ) u_misr (
      .clock (clock),
      .reset (reset),
      .clr   (misr_clr),
      .en    (misr_en),
      .d     (misr_din),
      .sig   (misr_sig)
   );

   assign bist_running = (state_q == ST_INIT)    || (state_q == ST_SHIFT)  ||
                         (state_q == ST_CAPTURE) || (state_q == ST_UNLOAD) ||
                         (state_q == ST_COMPARE);
   assign bist_end     = (state_q == ST_DONE);
   assign pass_fail    = pass_fail_q;
   assign signature    = misr_sig;
   assign cut_in       = bist_running ? lfsr_q[N_IN-1:0] : func_in;

endmodule

`default_nettype wire

// File: tb/tb_bist_engine.sv
// ----------------------------------------------------------------------------
// tb_bist_engine : directed bench with a small scan-CUT model per engine.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bist_engine;

   localparam int A_NIN = 4;
   localparam int A_LEN = 8;
   localparam int B_NIN = 3;
   localparam int B_LEN = 1;

   // Full-system reference: LFSR source, CUT model and MISR walked through the run.
   function automatic logic [15:0] model_sig(input int n_in, input int len,
                                             input int n_pat, input bit fault);
      logic [7:0]  lfsr;
      logic [15:0] misr;
      logic [7:0]  ch;
      logic [3:0]  co;
      lfsr = 8'hFF;
      misr = 16'h0000;
      ch   = 8'h00;
      for (int p = 0; p < n_pat; p++) begin
         for (int s = 0; s <= len; s++) begin
            for (int j = 0; j < 4; j++) co[j] = ch[j % len] ^ lfsr[j % n_in];
            if (fault) co[0] = 1'b0;
            misr = {misr[14:0], ^(misr & 16'hB400)} ^ {11'b0, co, ch[len-1]};
            if (s < len) begin
               ch = {ch[6:0], lfsr[7]};
            end else begin
               for (int i = 0; i < len; i++) ch[i] = ch[i] ^ lfsr[i % n_in];
            end
            lfsr = {lfsr[6:0], ^(lfsr & 8'hB8)};
         end
      end
      for (int s = 0; s < len; s++) begin
         for (int j = 0; j < 4; j++) co[j] = ch[j % len] ^ lfsr[j % n_in];
         if (fault) co[0] = 1'b0;
         misr = {misr[14:0], ^(misr & 16'hB400)} ^ {11'b0, co, ch[len-1]};
         ch   = {ch[6:0], 1'b0};
      end
      return misr;
   endfunction

   localparam logic [15:0] GOLD_A = model_sig(A_NIN, A_LEN, 16, 1'b0);
   localparam logic [15:0] GOLD_F = model_sig(A_NIN, A_LEN, 16, 1'b1);
   localparam logic [15:0] GOLD_S = model_sig(B_NIN, B_LEN, 1, 1'b0);

   logic clock;
   logic reset;

   logic             bist_start_a, bist_abort_a, scan_en_a, scan_in_a, scan_out_a;
   logic             running_a, end_a, pass_a, fault_a;
   logic [A_NIN-1:0] func_in_a, cut_in_a;
   logic [3:0]       cut_out_a;
   logic [15:0]      sig_a;

   logic             bist_start_b, bist_abort_b, scan_en_b, scan_in_b, scan_out_b;
   logic             running_b, end_b, pass_b;
   logic [B_NIN-1:0] func_in_b, cut_in_b;
   logic [3:0]       cut_out_b;
   logic [15:0]      sig_b;

   int errors = 0;
   int checks = 0;

   bist_engine #(.GOLDEN_SIG(GOLD_A)) dut_a (
      .clock(clock), .reset(reset), .bist_start(bist_start_a), .bist_abort(bist_abort_a),
      .func_in(func_in_a), .cut_in(cut_in_a), .cut_out(cut_out_a), .scan_en(scan_en_a),
      .scan_in(scan_in_a), .cut_scan_out(scan_out_a), .bist_running(running_a),
      .bist_end(end_a), .pass_fail(pass_a), .signature(sig_a)
   );

   bist_engine #(.N_IN(B_NIN), .SCAN_LEN(B_LEN), .N_PATTERNS(1), .GOLDEN_SIG(GOLD_S)) dut_b (
      .clock(clock), .reset(reset), .bist_start(bist_start_b), .bist_abort(bist_abort_b),
      .func_in(func_in_b), .cut_in(cut_in_b), .cut_out(cut_out_b), .scan_en(scan_en_b),
      .scan_in(scan_in_b), .cut_scan_out(scan_out_b), .bist_running(running_b),
      .bist_end(end_b), .pass_fail(pass_b), .signature(sig_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // CUT models: chain cleared while idle, captures only on the cycle scan_en drops.
   logic [7:0] ch_a, ch_b, cap_a, cap_b;
   logic       pse_a, pse_b;

   always_comb begin
      cut_out_a = '0;
      cap_a     = ch_a;
      for (int j = 0; j < 4; j++) cut_out_a[j] = ch_a[j % A_LEN] ^ cut_in_a[j % A_NIN];
      if (fault_a) cut_out_a[0] = 1'b0;
      for (int i = 0; i < A_LEN; i++) cap_a[i] = ch_a[i] ^ cut_in_a[i % A_NIN];
   end

   always_comb begin
      cut_out_b = '0;
      cap_b     = ch_b;
      for (int j = 0; j < 4; j++) cut_out_b[j] = ch_b[j % B_LEN] ^ cut_in_b[j % B_NIN];
      for (int i = 0; i < B_LEN; i++) cap_b[i] = ch_b[i] ^ cut_in_b[i % B_NIN];
   end

   assign scan_out_a = ch_a[A_LEN-1];
   assign scan_out_b = ch_b[B_LEN-1];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ch_a <= '0; pse_a <= 1'b0; ch_b <= '0; pse_b <= 1'b0;
      end else begin
         pse_a <= scan_en_a;
         pse_b <= scan_en_b;
         if (!running_a)     ch_a <= '0;
         else if (scan_en_a) ch_a <= {ch_a[6:0], scan_in_a};
         else if (pse_a)     ch_a <= cap_a;
         if (!running_b)     ch_b <= '0;
         else if (scan_en_b) ch_b <= {ch_b[6:0], scan_in_b};
         else if (pse_b)     ch_b <= cap_b;
      end
   end

   // Runs engine A; optionally re-pulses start at cycle poke_at. cyc=0 means timeout.
   task automatic run_a(input int poke_at, output int cyc, output int se_err);
      logic exp_se;
      cyc    = 0;
      se_err = 0;
      bist_start_a = 1'b1;
      @(posedge clock); #1;
      bist_start_a = 1'b0;
      for (int k = 1; k <= 400; k++) begin
         @(posedge clock); #1;
         if (k <= 144)      exp_se = ((k - 1) % 9) < 8;
         else if (k <= 152) exp_se = 1'b1;
         else               exp_se = 1'b0;
         bist_start_a = (k == poke_at);
         if (k < 154 && (scan_en_a !== exp_se || running_a !== 1'b1)) se_err++;
         if (end_a === 1'b1) begin
            cyc = k;
            break;
         end
      end
      bist_start_a = 1'b0;
   endtask

   task automatic run_b(output int cyc);
      cyc = 0;
      bist_start_b = 1'b1;
      @(posedge clock); #1;
      bist_start_b = 1'b0;
      for (int k = 1; k <= 50; k++) begin
         @(posedge clock); #1;
         if (end_b === 1'b1) begin
            cyc = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bist_start_a = 0; bist_abort_a = 0; func_in_a = '0; fault_a = 0;
      bist_start_b = 0; bist_abort_b = 0; func_in_b = '0;
      repeat (3) @(posedge clock);
      #2 reset = 1'b0;
      @(posedge clock); #1;
      checks++; if ({running_a, end_a, pass_a, scan_en_a, scan_in_a} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: got %b want 00000", {running_a, end_a, pass_a, scan_en_a, scan_in_a});
      end
      checks++; if (sig_a !== 16'h0000) begin
         errors++; $display("FAIL reset_sig: got %h want 0000", sig_a);
      end
   endtask

   task automatic test_mission();
      func_in_a = 4'b1010; #1;
      checks++; if (cut_in_a !== 4'b1010) begin
         errors++; $display("FAIL mission_1010: got %b want 1010", cut_in_a);
      end
      func_in_a = 4'b0101; #1;
      checks++; if (cut_in_a !== 4'b0101) begin
         errors++; $display("FAIL mission_0101: got %b want 0101", cut_in_a);
      end
      checks++; if ({scan_en_a, running_a, end_a} !== 3'b000) begin
         errors++; $display("FAIL mission_flags: got %b want 000", {scan_en_a, running_a, end_a});
      end
   endtask

   task automatic test_full_run(input bit fault, input string tag);
      int cyc, se_err;
      fault_a = fault;
      run_a(0, cyc, se_err);
      checks++; if (cyc !== 154) begin
         errors++; $display("FAIL %s_cycles: got %0d want 154", tag, cyc);
      end
      checks++; if (se_err !== 0) begin
         errors++; $display("FAIL %s_scan_en_seq: got %0d bad cycles want 0", tag, se_err);
      end
      checks++; if (pass_a !== !fault) begin
         errors++; $display("FAIL %s_pass_fail: got %b want %b", tag, pass_a, !fault);
      end
      checks++; if (sig_a !== (fault ? GOLD_F : GOLD_A)) begin
         errors++; $display("FAIL %s_sig: got %h want %h", tag, sig_a, fault ? GOLD_F : GOLD_A);
      end
      if (fault) begin
         checks++; if (sig_a === GOLD_A) begin
            errors++; $display("FAIL fault_sig_differs: got %h want not %h", sig_a, GOLD_A);
         end
      end
      fault_a = 1'b0;
   endtask

   task automatic test_abort();
      int cyc, se_err;
      func_in_a = 4'b0110;
      bist_start_a = 1'b1;
      @(posedge clock); #1;
      bist_start_a = 1'b0;
      repeat (49) @(posedge clock);
      #1;
      checks++; if (running_a !== 1'b1) begin
         errors++; $display("FAIL abort_pre_running: got %b want 1", running_a);
      end
      bist_abort_a = 1'b1;
      @(posedge clock); #1;
      bist_abort_a = 1'b0;
      checks++; if ({running_a, end_a, pass_a, scan_en_a} !== 4'b0000) begin
         errors++; $display("FAIL abort_flags: got %b want 0000", {running_a, end_a, pass_a, scan_en_a});
      end
      checks++; if (cut_in_a !== 4'b0110) begin
         errors++; $display("FAIL abort_cut_in: got %b want 0110", cut_in_a);
      end
      run_a(0, cyc, se_err);
      checks++; if (cyc !== 154 || pass_a !== 1'b1) begin
         errors++; $display("FAIL abort_rerun: got cyc=%0d pass=%b want cyc=154 pass=1", cyc, pass_a);
      end
      // From DONE, abort beats a simultaneous start.
      bist_start_a = 1'b1; bist_abort_a = 1'b1;
      @(posedge clock); #1;
      bist_start_a = 1'b0; bist_abort_a = 1'b0;
      checks++; if ({running_a, end_a, pass_a} !== 3'b000) begin
         errors++; $display("FAIL abort_priority: got %b want 000", {running_a, end_a, pass_a});
      end
   endtask

   task automatic test_reset_midrun();
      int cyc, se_err;
      func_in_a = 4'b1001;
      bist_start_a = 1'b1;
      @(posedge clock); #1;
      bist_start_a = 1'b0;
      repeat (30) @(posedge clock);
      #3 reset = 1'b1;
      #1;
      checks++; if ({running_a, end_a, pass_a, scan_en_a} !== 4'b0000 || sig_a !== 16'h0000) begin
         errors++; $display("FAIL reset_midrun: got flags=%b sig=%h want 0000/0000",
                            {running_a, end_a, pass_a, scan_en_a}, sig_a);
      end
      checks++; if (cut_in_a !== 4'b1001) begin
         errors++; $display("FAIL reset_midrun_cut_in: got %b want 1001", cut_in_a);
      end
      #2 reset = 1'b0;
      @(posedge clock); #1;
      run_a(40, cyc, se_err);
      checks++; if (cyc !== 154 || se_err !== 0 || pass_a !== 1'b1) begin
         errors++; $display("FAIL start_ignored: got cyc=%0d se_err=%0d pass=%b want 154/0/1", cyc, se_err, pass_a);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      for (int r = 0; r < 2; r++) begin
         run_b(cyc);
         checks++; if (cyc !== 5) begin
            errors++; $display("FAIL sweep_cycles_run%0d: got %0d want 5", r, cyc);
         end
         checks++; if (sig_b !== GOLD_S || pass_b !== 1'b1) begin
            errors++; $display("FAIL sweep_sig_run%0d: got sig=%h pass=%b want sig=%h pass=1", r, sig_b, pass_b, GOLD_S);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mission();
      test_full_run(1'b0, "good");
      test_full_run(1'b1, "fault");
      test_abort();
      test_reset_midrun();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
